sha1_padder: RTL
================

Name: sha1_padder

Overview:
- Front end for the SHA-1 core: accepts a byte stream of one message and emits FIPS 180-4 padded 512-bit blocks to the hash core.
- Padding appends 0x80, zero fill, and the 64-bit big-endian message bit length.
- Sits between the host or byte source and the block input of the SHA-1 core, which receives data as message_in[511:0].
- Produces the extra final block when the length field does not fit.

Parameters:
- LEN_W, 32, width of internal byte counter; message length in bits = byte_count<<3, zero-extended to 64.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  8  message byte.
- in_valid  input  1  byte valid.
- in_last  input  1  final byte of message; qualified by in_valid.
- in_nodata  input  1  with in_last: in_data ignored (supports zero-length and exactly-aligned termination).
- in_ready  output  1  byte accepted when in_valid && in_ready.
- blk_data  output  512  padded block; byte 0 of block at [511:504].
- blk_valid  output  1  block available.
- blk_ready  input  1  core accepts block.
- blk_first  output  1  block is first of message (core loads initial H).
- blk_last  output  1  block is final of message (digest valid after core finishes it).
- len_err  output  1  sticky overflow flag (only with optional feature).

Behaviour:
- Async reset (reset_n low): state=FILL, byte_idx=0, byte_count=0, first_flag=1, buffer=0, in_ready=0 for the reset cycle. After release: in_ready=1, blk_valid=0, blk_first=0, blk_last=0, len_err=0.
- States: FILL, EMIT, EXTRA, EMIT_LAST.
- FILL:
  - in_ready=1.
  - On an accepted byte without in_nodata: write buf[byte_idx], increment byte_idx (6-bit wrap) and byte_count.
  - If byte_idx was 63 and not last: go to EMIT with blk_last=0.
  - On an accepted in_last, pad in the same cycle:
    - Write 0x80 at the next free index p and zero bytes p+1..63.
    - If p<=55: place the length in bytes 56..63 and go to EMIT with blk_last=1.
    - Else (56<=p<=63): go to EMIT with blk_last=0, then EXTRA.
    - If the last byte fills index 63 (p=64): go to EMIT with blk_last=0, then EXTRA, whose block starts with 0x80.
- EMIT:
  - blk_valid=1 and in_ready=0.
  - blk_data, blk_first and blk_last are held stable until blk_ready.
  - On handshake: clear the buffer and set first_flag=0.
  - Next state: EXTRA if pending, FILL if not last, or FILL with message context reset (byte_count=0, first_flag=1) if last.
- EXTRA:
  - One cycle to build the block: 0x80 if pending-marker, else zeros; length in bytes 56..63.
  - Then EMIT_LAST, which behaves as EMIT with blk_last=1.
- blk_first=1 only on the first block of each message; a single-block message has blk_first=blk_last=1.
- Latency: final byte accepted to blk_valid asserted is 1 cycle; a full-block boundary is also 1 cycle.
- No byte accepted while blk_valid=1; in_valid during EMIT is stalled, not lost.
- in_nodata without in_last is ignored (no count, no write).
- Back-to-back messages are supported: the next message starts in FILL right after the final block handshake.

Optional Feature:
- SHA1_PADDER_LEN_CHECK_EN defined:
  - If an accepted byte would wrap byte_count past 2^LEN_W-1, set len_err (sticky until reset).
  - Drop bytes until in_last.
  - Emit no final block for that message; return to FILL.
- Macro undefined:
  - len_err tied 0.
  - byte_count wraps silently modulo 2^LEN_W.

Decomposition:
- Package sha1_pkg:
  - SHA1_BLOCK_BITS=512, SHA1_LEN_FIELD_BITS=64, SHA1_PAD_BYTE=8'h80, SHA1_LEN_LIMIT_BYTE=55.
  - State enum for the padder.
  - Initial H constants, shared with the core.
- Sub-module sha1_block_buf:
  - 64-byte register array with indexed byte write, clear, and length-field insert.
  - The padder FSM drives it.

Test Plan:
- "abc" (61 62 63, last on 63): one block = 0x61626380 followed by zeros, final word 0x00000018; blk_first=blk_last=1.
- Zero-length (in_last+in_nodata): one block 0x80000000…00, length 0; first=last=1.
- 56 bytes 0xAA: block 1 = 56×AA,80,7×00 (first=1, last=0); block 2 = zeros with length 0x1C0 (last=1).
- 64 bytes 0x00 then in_nodata+in_last: block 1 all zero; block 2 = 0x80…, length 0x200.
- "abc" with blk_ready low 10 cycles, then high: blk_data stable throughout, in_ready=0, one handshake only.
- Assert reset_n low mid-FILL after 30 bytes: outputs cleared immediately; a new "abc" then yields the correct single block.

Source files
------------

// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: block geometry, padding constants, initial hash
// values used by the core, and the padder state type.
package sha1_pkg;

  localparam int          SHA1_BLOCK_BITS     = 512;
  localparam int          SHA1_BLOCK_BYTES    = SHA1_BLOCK_BITS / 8;
  localparam int          SHA1_LEN_FIELD_BITS = 64;
  localparam logic [7:0]  SHA1_PAD_BYTE       = 8'h80;
  localparam int          SHA1_LEN_LIMIT_BYTE = 55;

  localparam logic [31:0] SHA1_H0 = 32'h6745_2301;
  localparam logic [31:0] SHA1_H1 = 32'hEFCD_AB89;
  localparam logic [31:0] SHA1_H2 = 32'h98BA_DCFE;
  localparam logic [31:0] SHA1_H3 = 32'h1032_5476;
  localparam logic [31:0] SHA1_H4 = 32'hC3D2_E1F0;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_EXTRA,
    ST_EMIT_LAST
  } padder_state_e;

endpackage

// File: rtl/sha1_block_buf.sv
// 64-byte block buffer for the SHA-1 padder: indexed byte write, clear,
// 0x80 marker with zero fill above it, and big-endian length insert.
module sha1_block_buf
  import sha1_pkg::*;
(
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           clr_i,
  input  logic                           wr_en_i,
  input  logic [5:0]                     wr_idx_i,
  input  logic [7:0]                     wr_data_i,
  input  logic                           pad_en_i,
  input  logic [6:0]                     pad_idx_i,
  input  logic                           len_en_i,
  input  logic [SHA1_LEN_FIELD_BITS-1:0] len_i,
  output logic [SHA1_BLOCK_BITS-1:0]     blk_o
);

  logic [7:0] mem_q [SHA1_BLOCK_BYTES];
  logic [7:0] mem_d [SHA1_BLOCK_BYTES];

  // NOTE: mem_d starts from mem_q so every path assigns it; no latch is inferred.
  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      for (int i = 0; i < SHA1_BLOCK_BYTES; i++) mem_d[i] = '0;
    end
    if (wr_en_i) mem_d[wr_idx_i] = wr_data_i;
    if (pad_en_i) begin
      for (int i = 0; i < SHA1_BLOCK_BYTES; i++) begin
        if (7'(i) == pad_idx_i)     mem_d[i] = SHA1_PAD_BYTE;
        else if (7'(i) > pad_idx_i) mem_d[i] = '0;
      end
    end
    if (len_en_i) begin
      for (int k = 0; k < 8; k++) mem_d[56+k] = len_i[63-8*k -: 8];
    end
  end

  // NOTE: the array is reset (not left X) because zero fill relies on bytes
  // that were never written being 0; updates use <= so all bytes move together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SHA1_BLOCK_BYTES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    for (int i = 0; i < SHA1_BLOCK_BYTES; i++) blk_o[SHA1_BLOCK_BITS-1-8*i -: 8] = mem_q[i];
  end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: byte stream in, padded 512-bit blocks out.
// Optional length-overflow detection with `define SHA1_PADDER_LEN_CHECK_EN.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  input  logic                       in_nodata,
  output logic                       in_ready,
  output logic [SHA1_BLOCK_BITS-1:0] blk_data,
  output logic                       blk_valid,
  input  logic                       blk_ready,
  output logic                       blk_first,
  output logic                       blk_last,
  output logic                       len_err
);

  padder_state_e state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [LEN_W-1:0] count_q, count_d, count_inc;
  logic first_q, first_d, last_q, last_d, pend_q, pend_d, mark_q, mark_d, live_q;
  logic buf_clr, buf_wr, buf_pad, buf_len;
  logic [6:0] pad_idx, p;
  logic [SHA1_LEN_FIELD_BITS-1:0] len_field;
  logic accept, real_byte, is_last, ovf, dropping;

  assign in_ready  = live_q && (state_q == ST_FILL);
  assign accept    = in_valid && in_ready;
  assign real_byte = accept && !in_nodata;
  assign is_last   = accept && in_last;
  assign count_inc = count_q + LEN_W'(real_byte);
  assign p         = {1'b0, idx_q} + 7'(real_byte);
  assign len_field = SHA1_LEN_FIELD_BITS'({count_inc, 3'b000});
  assign blk_first = blk_valid && first_q;
  assign blk_last  = blk_valid && last_q;

`ifdef SHA1_PADDER_LEN_CHECK_EN
  logic drop_q, err_q;
  assign ovf      = real_byte && (&count_q);
  assign dropping = drop_q;
  assign len_err  = err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept && (drop_q || ovf)) drop_q <= !in_last;
      if (ovf) err_q <= 1'b1;
    end
  end
`else
  assign ovf      = 1'b0;
  assign dropping = 1'b0;
  assign len_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
      idx_q   <= '0;
      count_q <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      pend_q  <= 1'b0;
      mark_q  <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      first_q <= first_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
      mark_q  <= mark_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    count_d   = count_q;
    first_d   = first_q;
    last_d    = last_q;
    pend_d    = pend_q;
    mark_d    = mark_q;
    buf_clr   = 1'b0;
    buf_wr    = 1'b0;
    buf_pad   = 1'b0;
    buf_len   = 1'b0;
    pad_idx   = p;
    blk_valid = 1'b0;
    unique case (state_q)
      ST_FILL: begin
        if (dropping || ovf) begin
          // Overflowed message: discard everything up to its last beat.
          if (is_last) begin
            buf_clr = 1'b1;
            idx_d   = '0;
            count_d = '0;
            first_d = 1'b1;
          end
        end else begin
          if (real_byte) begin
            buf_wr  = 1'b1;
            idx_d   = idx_q + 6'd1;
            count_d = count_inc;
          end
          if (is_last) begin
            buf_pad = 1'b1;
            idx_d   = '0;
            state_d = ST_EMIT;
            if (p <= 7'(SHA1_LEN_LIMIT_BYTE)) begin
              buf_len = 1'b1;
              last_d  = 1'b1;
              pend_d  = 1'b0;
            end else begin
              last_d  = 1'b0;
              pend_d  = 1'b1;
              mark_d  = (p == 7'd64);
            end
          end else if (real_byte && idx_q == 6'd63) begin
            state_d = ST_EMIT;
            last_d  = 1'b0;
            pend_d  = 1'b0;
          end
        end
      end
      ST_EMIT, ST_EMIT_LAST: begin
        blk_valid = 1'b1;
        if (blk_ready) begin
          buf_clr = 1'b1;
          first_d = 1'b0;
          if (state_q == ST_EMIT && pend_q) begin
            state_d = ST_EXTRA;
          end else begin
            state_d = ST_FILL;
            if (last_q) begin
              count_d = '0;
              first_d = 1'b1;
            end
          end
        end
      end
      ST_EXTRA: begin
        // Buffer was cleared on the previous handshake; only marker and length remain.
        buf_pad = mark_q;
        pad_idx = '0;
        buf_len = 1'b1;
        last_d  = 1'b1;
        pend_d  = 1'b0;
        state_d = ST_EMIT_LAST;
      end
      default: state_d = ST_FILL;
    endcase
  end

  sha1_block_buf u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (buf_clr),
    .wr_en_i   (buf_wr),
    .wr_idx_i  (idx_q),
    .wr_data_i (in_data),
    .pad_en_i  (buf_pad),
    .pad_idx_i (pad_idx),
    .len_en_i  (buf_len),
    .len_i     (len_field),
    .blk_o     (blk_data)
  );

endmodule
